keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad (active-low columns out, active-low rows in) and
//  debounces presses. Each confirmed key shifts its 4-bit hex code into a
//  32-bit entry register, which feeds the CPU data input or the 7-seg display.
//  Input-side counterpart of the multiplexed 7-seg display driver.
// PARAMETERS
//  SCAN_DIV  50000  clk cycles per scan tick (column step / sample period), >=2
//  DEB_CNT   20     consecutive matching ticks to accept a press or a release, >=1
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  ROW        in   4   keypad rows, active-low, asynchronous (pulled up on board)
//  COL        out  4   keypad column drive, active-low, one-hot-zero
//  clr        in   1   synchronous clear of data_out
//  data_out   out  32  entered digits, newest digit in [3:0]
//  key_code   out  4   code of the last accepted key
//  key_valid  out  1   one-clk pulse when a key is accepted
// BEHAVIOUR
//  Reset: COL=4'b1110, data_out=0, key_code=0, key_valid=0, state=SCAN,
//   col index=0, tick counter=0, debounce counters=0, sync FFs=4'b1111.
//  ROW passes a 2-FF synchronizer (rs) before any use.
//  Tick: counter 0..SCAN_DIV-1; tick=1 for one clk when counter==SCAN_DIV-1, then wraps.
//  COL = ~(4'b0001 << col); changes only in the clk after a tick.
//  States (all transitions evaluated on tick only):
//   SCAN: rs has exactly one bit low -> latch row/col, db=0, go DEBOUNCE,
//     col held. Otherwise (all high or >=2 low) -> col=col+1, 3 wraps to 0.
//   DEBOUNCE: rs == latched pattern -> db=db+1. When db reaches DEB_CNT ->
//     accept, go HOLD. Any mismatch -> db=0, col=col+1, go SCAN.
//   HOLD: col held. rs==4'b1111 -> rel=rel+1, else rel=0. When rel reaches
//     DEB_CNT -> rel=0, col=col+1, go SCAN. No second key until released.
//  Accept: key_valid=1 in the clk after the accepting tick; key_code and
//   data_out={data_out[27:0],code} update in that same clk. Oldest digit drops.
//  Key map [row][col]: r0:1 2 3 A  r1:4 5 6 B  r2:7 8 9 C  r3:E 0 F D.
//  clr and accept in the same clk: data_out=0 (clr wins); key_code and
//   key_valid update as usual. clr does not affect state or scanning.
//  Latency: press stable at ROW -> key_valid within (4+DEB_CNT+1)*SCAN_DIV+3 clk.
//  rst mid-operation: immediate return to reset values; no pulse is emitted.
// TESTING (SCAN_DIV=4, DEB_CNT=3)
//  Reset, ROW=1111 for 64 clk -> COL cycles 1110,1101,1011,0111,1110, 4 clk each;
//   key_valid never 1; data_out=0.
//  Hold key r1c2 ("6") low while COL=1011 -> COL freezes at 1011; exactly one
//   key_valid pulse 3 ticks after detection; key_code=6, data_out=32'h6.
//  Press 1,2,3,A,4,5,6,B,7 with a full release between each -> data_out=32'h23A456B7.
//  Glitch r0c0 low for 1 tick only -> no key_valid; scan resumes at next column.
//  Hold "5" for 50 ticks, then release -> single pulse; next key only after 3 all-high ticks.
//  Two rows low in same column -> ignored; clr coincident with accept -> data_out=0, pulse still seen.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix lines, clear strobe and entry outputs.
// master drives rows and clear, slave is the scanner.
interface keypad_scanner_if;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic        clr;
    logic [31:0] data_out;
    logic [3:0]  key_code;
    logic        key_valid;

    modport master (
        output ROW, clr,
        input  COL, data_out, key_code, key_valid
    );

    modport slave (
        input  ROW, clr,
        output COL, data_out, key_code, key_valid
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Accepted keys shift their hex code into a 32-bit entry register.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 20
) (
    input logic             clk,
    input logic             rst,
    keypad_scanner_if.slave kp
);
    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } state_t;

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
    // nibble {row,col} holds the legend of that key
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [3:0]    lat;
    logic [1:0]    lat_row;
    logic [1:0]    col;
    logic [DW-1:0] db;
    logic [DW-1:0] rel;
    logic          one_low;
    logic [1:0]    row_idx;
    logic [3:0]    code;

    assign tick   = (cnt == TICK_LAST);
    assign kp.COL = ~(4'b0001 << col);
    assign code   = KEYMAP[{lat_row, col, 2'b00} +: 4];

    always_comb begin
        one_low = 1'b1;
        row_idx = 2'd0;
        case (rs)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= kp.ROW;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SCAN;
            col          <= 2'd0;
            db           <= '0;
            rel          <= '0;
            lat          <= 4'hF;
            lat_row      <= 2'd0;
            kp.key_valid <= 1'b0;
            kp.key_code  <= 4'h0;
            kp.data_out  <= 32'h0;
        end else begin
            kp.key_valid <= 1'b0;
            if (kp.clr) begin
                kp.data_out <= 32'h0;
            end
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (one_low) begin
                            lat     <= rs;
                            lat_row <= row_idx;
                            db      <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs != lat) begin
                            db    <= '0;
                            col   <= col + 2'd1;
                            state <= SCAN;
                        end else if (db == DEB_LAST) begin
                            db           <= '0;
                            rel          <= '0;
                            state        <= HOLD;
                            kp.key_valid <= 1'b1;
                            kp.key_code  <= code;
                            // clear beats the new digit
                            if (!kp.clr) begin
                                kp.data_out <= {kp.data_out[27:0], code};
                            end
                        end else begin
                            db <= db + DW'(1);
                        end
                    end
                    HOLD: begin
                        if (rs != 4'hF) begin
                            rel <= '0;
                        end else if (rel == DEB_LAST) begin
                            rel   <= '0;
                            col   <= col + 2'd1;
                            state <= SCAN;
                        end else begin
                            rel <= rel + DW'(1);
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model plus tick-level
// reference of scan, debounce, release and digit entry.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pulses = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEB_CNT (DEB_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    always #5 clk = ~clk;

    // a pressed key shorts its row to its column when that column is driven low
    always_comb begin
        kp.ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp.COL[c]) begin
                    kp.ROW[r] = 1'b0;
                end
            end
        end
    end

    int keytab[16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                       7, 8, 9, 12, 14, 0, 15, 13};

    int          e;
    int          cidx;
    int          mode;
    int          run;
    int          quiet;
    logic [3:0]  m_meta;
    logic [3:0]  m_rs;
    logic [3:0]  rsu;
    logic [3:0]  lat;
    logic        mv;
    logic [3:0]  mc;
    logic [31:0] md;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] col_of(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic model_step();
        int ri;
        if (rst) begin
            e = 0; cidx = 0; mode = 0; run = 0; quiet = 0;
            m_meta = 4'hF; m_rs = 4'hF; lat = 4'hF;
            mv = 1'b0; mc = 4'h0; md = 32'h0;
        end else begin
            rsu = m_rs;
            m_rs = m_meta;
            m_meta = kp.ROW;
            mv = 1'b0;
            if (e % SCAN_DIV == SCAN_DIV - 1) begin
                if (mode == 0) begin
                    if ($countones(~rsu) == 1) begin
                        lat = rsu; run = 0; mode = 1;
                    end else begin
                        cidx = (cidx + 1) % 4;
                    end
                end else if (mode == 1) begin
                    if (rsu == lat) begin
                        run++;
                        if (run == DEB_CNT) begin
                            ri = 0;
                            for (int r = 0; r < 4; r++)
                                if (!lat[r]) ri = r;
                            mv = 1'b1;
                            mc = 4'(keytab[ri*4+cidx]);
                            md = {md[27:0], mc};
                            mode = 2; quiet = 0;
                        end
                    end else begin
                        cidx = (cidx + 1) % 4;
                        mode = 0;
                    end
                end else begin
                    if (rsu == 4'hF) begin
                        quiet++;
                        if (quiet == DEB_CNT) begin
                            cidx = (cidx + 1) % 4;
                            mode = 0;
                        end
                    end else begin
                        quiet = 0;
                    end
                end
            end
            if (kp.clr) md = 32'h0;
            e++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("col", 32'(kp.COL), 32'(col_of(cidx)));
        chk("valid", 32'(kp.key_valid), 32'(mv));
        chk("code", 32'(kp.key_code), 32'(mc));
        chk("data", kp.data_out, md);
        if (kp.key_valid) pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input int k, input int hold, input int gap);
        keys = '0;
        keys[k] = 1'b1;
        cyc(hold);
        keys = '0;
        cyc(gap);
    endtask

    task automatic wait_col_start(input logic [3:0] target);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            prev = kp.COL;
            cyc(1);
            if (kp.COL == target && prev != target) found = 1'b1;
        end
        chk("wait_col", 32'(found), 32'd1);
    endtask

    initial begin
        int p0;
        int sel;
        int k1;
        int k2;
        logic hit;
        kp.clr = 1'b0;
        cyc(3);
        chk("rst_col", 32'(kp.COL), 32'hE);
        chk("rst_data", kp.data_out, 32'h0);
        chk("rst_valid", 32'(kp.key_valid), 32'h0);
        chk("rst_code", 32'(kp.key_code), 32'h0);
        rst = 1'b0;

        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            chk("col_scan", 32'(kp.COL), 32'(col_of((k / 4) % 4)));
        end
        cyc(48);
        chk("idle_pulses", pulses, 0);
        chk("idle_data", kp.data_out, 32'h0);

        p0 = pulses;
        press(6, 80, 40);
        chk("six_pulses", pulses - p0, 1);
        chk("six_code", 32'(kp.key_code), 32'h6);
        chk("six_data", kp.data_out, 32'h6);

        p0 = pulses;
        for (int i = 0; i < 9; i++) press(i, 80, 40);
        chk("seq_pulses", pulses - p0, 9);
        chk("seq_data", kp.data_out, 32'h23A456B7);

        p0 = pulses;
        wait_col_start(4'b1110);
        keys[0] = 1'b1;
        cyc(SCAN_DIV);
        keys = '0;
        cyc(40);
        chk("glitch_pulses", pulses - p0, 0);

        p0 = pulses;
        press(5, 50 * SCAN_DIV, 40);
        chk("hold_pulses", pulses - p0, 1);
        chk("hold_code", 32'(kp.key_code), 32'h5);

        p0 = pulses;
        keys[5] = 1'b1;
        cyc(80);
        keys = '0;
        cyc(2 * SCAN_DIV);
        keys[5] = 1'b1;
        cyc(80);
        keys = '0;
        cyc(40);
        chk("bounce_pulses", pulses - p0, 1);

        p0 = pulses;
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        cyc(100);
        keys = '0;
        cyc(20);
        chk("tworow_pulses", pulses - p0, 0);

        keys[10] = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (e % SCAN_DIV == SCAN_DIV - 1 && mode == 1 &&
                run == DEB_CNT - 1 && m_rs == lat) begin
                hit = 1'b1;
            end else begin
                cyc(1);
            end
        end
        chk("clracc_found", 32'(hit), 32'd1);
        kp.clr = 1'b1;
        cyc(1);
        kp.clr = 1'b0;
        chk("clracc_valid", 32'(kp.key_valid), 32'd1);
        chk("clracc_code", 32'(kp.key_code), 32'h9);
        chk("clracc_data", kp.data_out, 32'h0);
        keys = '0;
        cyc(40);

        press(13, 80, 40);
        chk("zero_data", kp.data_out, 32'h0);
        press(14, 80, 40);
        chk("f_data", kp.data_out, 32'hF);
        kp.clr = 1'b1;
        cyc(1);
        kp.clr = 1'b0;
        chk("clr_data", kp.data_out, 32'h0);

        keys[15] = 1'b1;
        cyc(30);
        rst = 1'b1;
        p0 = pulses;
        cyc(1);
        chk("mid_rst_col", 32'(kp.COL), 32'hE);
        chk("mid_rst_valid", 32'(kp.key_valid), 32'h0);
        chk("mid_rst_data", kp.data_out, 32'h0);
        keys = '0;
        cyc(2);
        rst = 1'b0;
        cyc(60);
        chk("mid_rst_pulses", pulses - p0, 0);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            k1 = $urandom_range(0, 15);
            k2 = $urandom_range(0, 15);
            if (sel < 6) begin
                press(k1, $urandom_range(20, 150), $urandom_range(10, 60));
            end else if (sel < 8) begin
                keys[k1] = 1'b1;
                keys[k2] = 1'b1;
                cyc($urandom_range(20, 120));
                keys = '0;
                cyc($urandom_range(10, 60));
            end else if (sel == 8) begin
                press(k1, $urandom_range(1, 6), $urandom_range(4, 30));
            end else begin
                keys[k1] = 1'b1;
                cyc($urandom_range(1, 60));
                kp.clr = 1'b1;
                cyc(1);
                kp.clr = 1'b0;
                cyc($urandom_range(10, 80));
                keys = '0;
                cyc($urandom_range(10, 60));
            end
        end
        cyc(40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
